cnn_apb_mmu_mc: RTL
===================

// Module: cnn_apb_mmu_mc
// PURPOSE
//  Parametrised APB slave front-end for the CNN conv core: register file, pixel FIFO, multi-channel
//  OFM SRAM arbitration and interrupt. Sits between PULPino APB bus and conv core + single-port OFM SRAM.
//  Successor to single-channel wrapper: N channels, buffered pixels, W1C status, proper wait-state reads.
// PARAMETERS
//  APB_ADDR_WIDTH  12   APB address width; register index = PADDR[5:2]
//  DATA_WIDTH      8    OFM element width (<=32)
//  IFM_SIZE        28   feature map side; OFM_DEPTH = IFM_SIZE*IFM_SIZE per channel
//  NUM_CH          4    OFM channels (>=1); CH_BITS = max(1,$clog2(NUM_CH))
//  FIFO_DEPTH      4    pixel FIFO entries (power of 2, >=2)
// PORTS
//  HCLK  in 1  clock | HRESETn  in 1  async active-low reset
//  PADDR in APB_ADDR_WIDTH | PWDATA in 32 | PWRITE,PSEL,PENABLE in 1 | PRDATA out 32 | PREADY,PSLVERR out 1
//  irq_o  out 1  level interrupt: finish_sticky & irq_en
//  conv_start_o out 1 start pulse | weight_o out 32, weight_valid_o out 1  one-cycle push
//  pic_o out 32, pic_valid_o out 1, pic_ready_i in 1  FIFO head, valid/ready handshake
//  need_pic_i, conv_finish_i  in 1  core event pulses
//  res_valid_i in 1, res_data_i in DATA_WIDTH, res_addr_i in ADDR_BITS, res_ch_i in CH_BITS  result write
//  prev_rd_en_i in 1  core read request (uses res_addr_i/res_ch_i) | prev_valid_o out 1, prev_data_o out DATA_WIDTH
//  sram_en_o, sram_we_o out 1 | sram_addr_o out CH_BITS+ADDR_BITS = {ch,pix} | sram_wdata_o out DATA_WIDTH
//  sram_rdata_i in DATA_WIDTH  valid one cycle after sram_en_o & !sram_we_o
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, ptr={0,0}, irq_en=0, status sticky bits 0, FSM IDLE.
//  Map (write on PSEL&PENABLE&PWRITE): 0x00 CTRL W bit0=start pulse (1 cyc), bit1=irq_en; R {finish,need_pic,fifo_full,fifo_empty,irq_en}
//   0x04 STATUS W1C bit0 need_pic, bit1 finish; R same | 0x08 PIXEL W push FIFO | 0x0C OFM_DATA R auto-increment
//   0x10 WEIGHT W one-cycle weight_valid_o | 0x14 OFM_PTR RW {ch[CH_BITS-1:0] at 16+, pix[ADDR_BITS-1:0]} | 0x18 FIFO_LVL R
//  Sticky: event pulse sets bit; W1C clears; set wins over same-cycle clear. PIXEL write also clears need_pic.
//  PIXEL write with FIFO full: PREADY=1, PSLVERR=1, data dropped. All other accesses PSLVERR=0; unmapped R=0.
//  FIFO: pop on pic_valid_o&pic_ready_i; push+pop same cycle when full/empty legal, level unchanged.
//  OFM read FSM IDLE->REQ->DATA->IDLE: REQ holds PREADY=0, issues SRAM read when no core access that cycle
//   (core has priority; REQ stalls until SRAM free); DATA: PREADY=1, PRDATA={0,sram_rdata_i}, ptr increments.
//   Min latency 2 wait-free cycles of access phase (1 wait state). Abort if PSEL drops: return IDLE, no increment.
//  Pointer wrap: pix==OFM_DEPTH-1 -> pix=0, ch+1; ch==NUM_CH-1 -> ch=0. OFM_PTR write with pix>=OFM_DEPTH or ch>=NUM_CH saturates to 0.
//  Core write: res_* registered one cycle then written (sram_we_o=1). Core read: prev_valid_o 1 cycle after prev_rd_en_i.
//  Core read and pending core write never coincide (protocol rule, SVA-checked); core read beats APB read.
//  PREADY=1 on all non-OFM_DATA accesses (zero wait). PRDATA=0 outside read access phase.
// STRUCTURE
//  Package cnn_mmu_pkg: register offset constants, status bit positions, ofm_rd_state_e enum.
//  Sub-module cnn_pix_fifo (sync FIFO, DATA=32, DEPTH=FIFO_DEPTH, level output); rest flat in this module.
// TESTING
//  Reset mid-OFM read (in REQ) -> PREADY=0 dropped, ptr={0,0}, irq_o=0, FIFO level 0.
//  Write PIXEL x5 (FIFO_DEPTH=4, pic_ready_i=0) -> first 4 PSLVERR=0, 5th PSLVERR=1; FIFO_LVL reads 4.
//  Core writes 0xA5 ch1 pix783; OFM_PTR={1,783}; read OFM_DATA -> 0x000000A5 after 1 wait state, ptr={2,0}.
//  APB OFM read while core prev_rd_en_i held 3 cycles -> PREADY low 4 cycles, core prev_valid_o unaffected.
//  conv_finish_i pulse with irq_en=1 -> irq_o=1; W1C 0x2 to STATUS -> irq_o=0 next cycle; pulse+clear same cycle -> stays 1.
//  Read OFM_DATA NUM_CH*OFM_DEPTH+1 times from {0,0} -> last read returns element {0,0} (full wrap).

Source files
------------

// File: rtl/cnn_mmu_pkg.sv
// cnn_mmu_pkg: register map, status bit positions and OFM read FSM states for the CNN APB front-end
package cnn_mmu_pkg;
   localparam logic [3:0] REG_CTRL     = 4'h0;
   localparam logic [3:0] REG_STATUS   = 4'h1;
   localparam logic [3:0] REG_PIXEL    = 4'h2;
   localparam logic [3:0] REG_OFM_DATA = 4'h3;
   localparam logic [3:0] REG_WEIGHT   = 4'h4;
   localparam logic [3:0] REG_OFM_PTR  = 4'h5;
   localparam logic [3:0] REG_FIFO_LVL = 4'h6;
   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int ST_NEED_PIC = 0;
   localparam int ST_FINISH   = 1;
   typedef enum logic [1:0] {OFM_IDLE, OFM_REQ, OFM_DATA} ofm_rd_state_e;
   function automatic int ch_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/cnn_pix_fifo.sv
// cnn_pix_fifo: synchronous pixel FIFO with level output; push while full is accepted only with a pop
module cnn_pix_fifo #(
   parameter int DATA  = 32,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            HCLK,
   input  logic            HRESETn,
   input  logic            push,
   input  logic [DATA-1:0] din,
   input  logic            pop,
   output logic [DATA-1:0] dout,
   output logic            full,
   output logic            empty,
   output logic [AW:0]     level
);
   logic [DATA-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic            do_push, do_pop;
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;
   assign full    = level == (AW+1)'(DEPTH);
   assign empty   = level == '0;
   assign dout    = empty ? '0 : mem[rd_ptr];
   // storage array, written at the tail
   always_ff @(posedge HCLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end
   // pointers and occupancy; power-of-two depth lets the pointers wrap naturally
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/cnn_apb_mmu_mc.sv
// cnn_apb_mmu_mc: APB register file, pixel FIFO, multi-channel OFM SRAM arbitration and interrupt
module cnn_apb_mmu_mc
   import cnn_mmu_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int DATA_WIDTH     = 8,
   parameter int IFM_SIZE       = 28,
   parameter int NUM_CH         = 4,
   parameter int FIFO_DEPTH     = 4,
   localparam int OFM_DEPTH     = IFM_SIZE * IFM_SIZE,
   localparam int ADDR_BITS     = $clog2(OFM_DEPTH),
   localparam int CH_BITS       = ch_bits(NUM_CH)
) (
   input  logic                        HCLK,
   input  logic                        HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0]   PADDR,
   input  logic [31:0]                 PWDATA,
   input  logic                        PWRITE,
   input  logic                        PSEL,
   input  logic                        PENABLE,
   output logic [31:0]                 PRDATA,
   output logic                        PREADY,
   output logic                        PSLVERR,
   output logic                        irq_o,
   output logic                        conv_start_o,
   output logic [31:0]                 weight_o,
   output logic                        weight_valid_o,
   output logic [31:0]                 pic_o,
   output logic                        pic_valid_o,
   input  logic                        pic_ready_i,
   input  logic                        need_pic_i,
   input  logic                        conv_finish_i,
   input  logic                        res_valid_i,
   input  logic [DATA_WIDTH-1:0]       res_data_i,
   input  logic [ADDR_BITS-1:0]        res_addr_i,
   input  logic [CH_BITS-1:0]          res_ch_i,
   input  logic                        prev_rd_en_i,
   output logic                        prev_valid_o,
   output logic [DATA_WIDTH-1:0]       prev_data_o,
   output logic                        sram_en_o,
   output logic                        sram_we_o,
   output logic [CH_BITS+ADDR_BITS-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0]       sram_wdata_o,
   input  logic [DATA_WIDTH-1:0]       sram_rdata_i
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   ofm_rd_state_e          state, state_nxt;
   logic [3:0]             idx;
   logic                   acc, wr_acc, rd_acc, ofm_sel;
   logic                   apb_issue, ptr_step, core_busy;
   logic [CH_BITS-1:0]     ptr_ch, wch;
   logic [ADDR_BITS-1:0]   ptr_pix, wpix;
   logic                   ptr_bad, last_pix, last_ch;
   logic                   res_valid_q;
   logic [DATA_WIDTH-1:0]  res_data_q;
   logic [ADDR_BITS-1:0]   res_addr_q;
   logic [CH_BITS-1:0]     res_ch_q;
   logic                   need_pic, finish, irq_en;
   logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [LVL_W-1:0]       fifo_level;
   logic [31:0]            rdata;
   logic                   unused_ok;
   assign idx       = PADDR[5:2];
   assign acc       = PSEL & PENABLE;
   assign wr_acc    = acc & PWRITE;
   assign rd_acc    = acc & ~PWRITE;
   assign ofm_sel   = PSEL & ~PWRITE & (idx == REG_OFM_DATA);
   assign core_busy = prev_rd_en_i | res_valid_q;
   assign unused_ok = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};
   assign wch       = PWDATA[16 +: CH_BITS];
   assign wpix      = PWDATA[ADDR_BITS-1:0];
   assign ptr_bad   = (32'(wpix) >= 32'(OFM_DEPTH)) | (32'(wch) >= 32'(NUM_CH));
   assign last_pix  = ptr_pix == ADDR_BITS'(OFM_DEPTH - 1);
   assign last_ch   = ptr_ch == CH_BITS'(NUM_CH - 1);
   assign fifo_push = wr_acc & (idx == REG_PIXEL) & ~fifo_full;
   assign fifo_pop  = pic_valid_o & pic_ready_i;
   assign pic_valid_o = ~fifo_empty;
   assign PREADY    = acc & (ofm_sel ? (state == OFM_DATA) : 1'b1);
   assign PSLVERR   = wr_acc & (idx == REG_PIXEL) & fifo_full;
   assign PRDATA    = rd_acc ? rdata : '0;
   assign irq_o     = finish & irq_en;
   assign sram_en_o    = prev_rd_en_i | res_valid_q | apb_issue;
   assign sram_we_o    = res_valid_q & ~prev_rd_en_i;
   assign sram_addr_o  = prev_rd_en_i ? {res_ch_i, res_addr_i} :
                         res_valid_q  ? {res_ch_q, res_addr_q} : {ptr_ch, ptr_pix};
   assign sram_wdata_o = res_data_q;
   assign prev_data_o  = prev_valid_o ? sram_rdata_i : '0;
   cnn_pix_fifo #(.DATA(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .push    (fifo_push),
      .din     (PWDATA),
      .pop     (fifo_pop),
      .dout    (pic_o),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );
   // OFM read FSM state register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= OFM_IDLE;
      else          state <= state_nxt;
   end
   // OFM read sequencing: armed in the setup phase, core traffic wins the SRAM, PSEL drop aborts
   always_comb begin
      state_nxt = state;
      apb_issue = 1'b0;
      ptr_step  = 1'b0;
      case (state)
         OFM_IDLE: state_nxt = ofm_sel ? OFM_REQ : OFM_IDLE;
         OFM_REQ: begin
            apb_issue = PSEL & ~core_busy;
            state_nxt = !PSEL ? OFM_IDLE : (core_busy ? OFM_REQ : OFM_DATA);
         end
         OFM_DATA: begin
            ptr_step  = acc;
            state_nxt = OFM_IDLE;
         end
         default: state_nxt = OFM_IDLE;
      endcase
   end
   // OFM pointer: software load (out-of-range loads clear it) or post-read increment with wrap
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ptr_ch  <= '0;
         ptr_pix <= '0;
      end else if (wr_acc && idx == REG_OFM_PTR) begin
         ptr_ch  <= ptr_bad ? '0 : wch;
         ptr_pix <= ptr_bad ? '0 : wpix;
      end else if (ptr_step) begin
         ptr_pix <= last_pix ? '0 : ptr_pix + ADDR_BITS'(1);
         ptr_ch  <= last_pix ? (last_ch ? '0 : ptr_ch + CH_BITS'(1)) : ptr_ch;
      end
   end
   // control, sticky status and one-cycle strobes; a set event beats a same-cycle clear
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         irq_en         <= 1'b0;
         need_pic       <= 1'b0;
         finish         <= 1'b0;
         conv_start_o   <= 1'b0;
         weight_valid_o <= 1'b0;
         weight_o       <= '0;
      end else begin
         irq_en         <= (wr_acc && idx == REG_CTRL) ? PWDATA[CTRL_IRQ_EN] : irq_en;
         need_pic       <= need_pic_i | (need_pic & ~(wr_acc & ((idx == REG_STATUS & PWDATA[ST_NEED_PIC]) | idx == REG_PIXEL)));
         finish         <= conv_finish_i | (finish & ~(wr_acc & idx == REG_STATUS & PWDATA[ST_FINISH]));
         conv_start_o   <= wr_acc & (idx == REG_CTRL) & PWDATA[CTRL_START];
         weight_valid_o <= wr_acc & (idx == REG_WEIGHT);
         weight_o       <= (wr_acc && idx == REG_WEIGHT) ? PWDATA : weight_o;
      end
   end
   // core result staging and core read valid
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         res_valid_q  <= 1'b0;
         res_data_q   <= '0;
         res_addr_q   <= '0;
         res_ch_q     <= '0;
         prev_valid_o <= 1'b0;
      end else begin
         res_valid_q  <= res_valid_i;
         res_data_q   <= res_valid_i ? res_data_i : res_data_q;
         res_addr_q   <= res_valid_i ? res_addr_i : res_addr_q;
         res_ch_q     <= res_valid_i ? res_ch_i : res_ch_q;
         prev_valid_o <= prev_rd_en_i;
      end
   end
   // register read mux
   always_comb begin
      rdata = '0;
      case (idx)
         REG_CTRL:     rdata = 32'({finish, need_pic, fifo_full, fifo_empty, irq_en});
         REG_STATUS:   rdata = 32'({finish, need_pic});
         REG_OFM_DATA: rdata = (state == OFM_DATA) ? 32'(sram_rdata_i) : '0;
         REG_OFM_PTR:  rdata = (32'(ptr_ch) << 16) | 32'(ptr_pix);
         REG_FIFO_LVL: rdata = 32'(fifo_level);
         default:      rdata = '0;
      endcase
   end
   core_rd_wr_excl: assert property (@(posedge HCLK) disable iff (!HRESETn) !(prev_rd_en_i && res_valid_q));
endmodule
